video_slot_arbiter: RTL and testbench
=====================================

// Module: video_slot_arbiter
// PURPOSE
// - Shares the 64-bit video read slot of the ST bus between three fetch engines.
// - Requesters: Viking/SM194 (0, hard real-time), ST shifter (1), sound/aux DMA (2).
// - Picks one winner per slot and drives the RAM address and read signals.
// - Captures the returned quad-word and strobes it back to the winner. Sits between video sources and the SDRAM controller.
// PARAMETERS
// - SLOT      2'd2  bus_cycle value in which video reads occur
// - AW        23    word address width
// - DW        64    data width
// - MAX_WAIT  8     slots a pending low-priority request may lose before forced grant (1..15)
// PORTS
// - clk        in   1    system clock; bus_cycle changes synchronously to it
// - reset      in   1    synchronous, active-high
// - bus_cycle  in   2    current bus phase (0..3)
// - req        in   3    level requests, bit i = requester i
// - addr0..2   in   AW   word address per requester, stable while req[i]=1
// - ram_read   out  1    read strobe to RAM controller
// - ram_addr   out  AW   address of granted requester
// - ram_data   in   DW   RAM read data, valid at end of slot
// - gnt        out  3    one-hot, winner of current/last slot
// - rd_valid   out  3    one-clk pulse, bit i = data for requester i on rd_data
// - rd_data    out  DW   captured quad-word
// BEHAVIOUR
// - Reset: ram_read=0, ram_addr=0, gnt=0, rd_valid=0, rd_data=0, rr_ptr=1, wait counters=0, state=IDLE.
// - slot_entry = (bus_cycle==SLOT) && (prev_bus_cycle!=SLOT); slot_exit = reverse.
// - FSM states: IDLE, GRANTED, CAPTURE.
//   - IDLE: on slot_entry with req!=0, register gnt/ram_addr and go to GRANTED.
//   - IDLE: on slot_entry with req==0, stay in IDLE with gnt=0.
//   - GRANTED: ram_read = (bus_cycle==SLOT). On slot_exit, go to CAPTURE.
//   - CAPTURE (one clk): rd_data<=ram_data, rd_valid<=gnt, gnt<=0, then IDLE.
// - Latency: ram_read high from 2nd clk of slot through its last clk.
//   - rd_valid pulses exactly one clk after the slot ends.
// - Priority at slot_entry, first match wins:
//   1. Any req[i] (i=1,2) with wait_cnt[i]>=MAX_WAIT. If both, rr_ptr decides.
//   2. req[0].
//   3. Round-robin between req[1] and req[2], starting at rr_ptr. rr_ptr toggles to the other after granting 1 or 2.
// - wait_cnt[i] (4 bit, i=1,2):
//   - clears when granted or req[i]=0;
//   - increments per slot_entry lost while requesting;
//   - saturates at 15, never wraps.
// - Request dropped mid-slot: grant held, read completes, rd_valid still pulses. Requester discards it.
// - New slot_entry while in CAPTURE is impossible (slot >=2 clks apart). If seen, arbitrate normally and still complete CAPTURE.
// - bus_cycle skipping SLOT entirely: no grant, counters unchanged.
// - Reset mid-slot: ram_read low next clk, no rd_valid, all state cleared.
// - gnt stays stable during a slot even if higher-priority req rises mid-slot.
// STRUCTURE
// - Shared package (video_pkg): SLOT, requester index constants (REQ_VIKING=0, REQ_SHIFTER=1, REQ_DMA=2), FSM state encoding, AW/DW.
// - One natural sub-module: slot_rr_pick.
//   - Combinational two-way round-robin with starvation override.
//   - Inputs: req[2:1], wait_cnt flags, rr_ptr, req[0]. Output: one-hot gnt.
// - Top holds the FSM, wait counters, address mux and capture register.
// TESTING
// - Only req[0] held, addr0=0x600000, 4 slots: 4 grants, ram_addr=0x600000, 4 rd_valid=3'b001 each 1 clk after slot.
// - req[1]+req[2] held, req[0]=0: gnt alternates 010,100,010,...; first grant 010 (rr_ptr=1).
// - req[0]+req[1] held for 10 slots: gnt=001 for 8 slots, gnt=010 on 9th (wait_cnt=8), 001 on 10th.
// - req[0] drops on 2nd clk of granted slot: ram_read stays high to slot end, rd_valid=001 still pulses with ram_data.
// - reset asserted mid-GRANTED: next clk ram_read=0, gnt=0; no rd_valid; next slot arbitrates fresh with rr_ptr=1.
// - req=0 for 3 slots: ram_read never high, rd_valid never pulses, wait counters stay 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and FSM encoding for the video read-slot arbiter.
package video_pkg;

    localparam logic [1:0] SLOT = 2'd2;
    localparam int AW = 23;
    localparam int DW = 64;
    localparam int MAX_WAIT = 8;
    localparam int WAIT_W = 4;

    localparam int REQ_VIKING  = 0;
    localparam int REQ_SHIFTER = 1;
    localparam int REQ_DMA     = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/slot_rr_pick.sv
// One-hot winner for a video slot: starved low-priority requesters first,
// then the Viking, then round-robin between shifter and DMA.
module slot_rr_pick
    import video_pkg::*;
(
    input  logic [2:1] i_req_lo,
    input  logic [2:1] i_starved,
    input  logic       i_rr_dma,
    input  logic       i_req_viking,
    output logic [2:0] o_gnt
);

    logic [2:1] w_starve;
    logic [2:0] w_rr_gnt;

    assign w_starve = i_req_lo & i_starved;
    // i_rr_dma=1 means the DMA engine holds round-robin priority.
    assign w_rr_gnt = i_rr_dma ? 3'b100 : 3'b010;

    always_comb begin
        o_gnt = 3'b000;
        if (&w_starve)
            o_gnt = w_rr_gnt;
        else if (w_starve[REQ_SHIFTER])
            o_gnt = 3'b010;
        else if (w_starve[REQ_DMA])
            o_gnt = 3'b100;
        else if (i_req_viking)
            o_gnt = 3'b001;
        else if (&i_req_lo)
            o_gnt = w_rr_gnt;
        else if (i_req_lo[REQ_SHIFTER])
            o_gnt = 3'b010;
        else if (i_req_lo[REQ_DMA])
            o_gnt = 3'b100;
    end

endmodule

// File: rtl/video_slot_arbiter.sv
// Arbitrates the 64-bit video read slot between Viking, shifter and sound DMA,
// issues the RAM read and returns the captured quad-word to the winner.
module video_slot_arbiter
    import video_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [1:0]    i_bus_cycle,
    input  logic [2:0]    i_req,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [AW-1:0] i_addr2,
    output logic          o_ram_read,
    output logic [AW-1:0] o_ram_addr,
    input  logic [DW-1:0] i_ram_data,
    output logic [2:0]    o_gnt,
    output logic [2:0]    o_rd_valid,
    output logic [DW-1:0] o_rd_data
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    arb_state_t        r_state, w_next_state;
    logic [1:0]        r_prev_bus;
    logic [2:0]        r_gnt;
    logic [AW-1:0]     r_ram_addr;
    logic [2:0]        r_rd_valid;
    logic [DW-1:0]     r_rd_data;
    logic [WAIT_W-1:0] r_wait1, r_wait2;
    logic              r_rr_dma;

    logic              w_slot_entry, w_slot_exit, w_arb;
    logic [2:0]        w_pick;
    logic [AW-1:0]     w_addr_sel;

    assign w_slot_entry = (i_bus_cycle == SLOT) && (r_prev_bus != SLOT);
    assign w_slot_exit  = (i_bus_cycle != SLOT) && (r_prev_bus == SLOT);
    // A slot entry seen during CAPTURE is still arbitrated.
    assign w_arb = w_slot_entry && (r_state != ST_GRANTED) && (|i_req);

    slot_rr_pick u_pick (
        .i_req_lo     (i_req[2:1]),
        .i_starved    ({r_wait2 >= WAIT_LIM, r_wait1 >= WAIT_LIM}),
        .i_rr_dma     (r_rr_dma),
        .i_req_viking (i_req[REQ_VIKING]),
        .o_gnt        (w_pick)
    );

    always_comb begin
        w_addr_sel = i_addr0;
        if (w_pick[REQ_SHIFTER])
            w_addr_sel = i_addr1;
        else if (w_pick[REQ_DMA])
            w_addr_sel = i_addr2;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        o_ram_read   = 1'b0;
        case (r_state)
            ST_IDLE:
                if (w_arb)
                    w_next_state = ST_GRANTED;
            ST_GRANTED: begin
                o_ram_read = (i_bus_cycle == SLOT);
                if (w_slot_exit)
                    w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE:
                w_next_state = w_arb ? ST_GRANTED : ST_IDLE;
            default:
                w_next_state = ST_IDLE;
        endcase
    end

    // Phase history is kept through reset so a reset inside a slot cannot fake an entry.
    always_ff @(posedge i_clk)
        r_prev_bus <= i_bus_cycle;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt      <= '0;
            r_ram_addr <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_wait1    <= '0;
            r_wait2    <= '0;
            r_rr_dma   <= 1'b0;
        end else begin
            r_rd_valid <= '0;
            if (w_arb) begin
                r_gnt      <= w_pick;
                r_ram_addr <= w_addr_sel;
                if (w_pick[REQ_SHIFTER] || w_pick[REQ_DMA])
                    r_rr_dma <= w_pick[REQ_SHIFTER];
            end else if (r_state == ST_CAPTURE) begin
                r_gnt <= '0;
            end

            if (r_state == ST_GRANTED && w_slot_exit) begin
                r_rd_valid <= r_gnt;
                r_rd_data  <= i_ram_data;
            end

            if (!i_req[REQ_SHIFTER] || (w_arb && w_pick[REQ_SHIFTER]))
                r_wait1 <= '0;
            else if (w_arb && r_wait1 != WAIT_SAT)
                r_wait1 <= r_wait1 + 1'b1;

            if (!i_req[REQ_DMA] || (w_arb && w_pick[REQ_DMA]))
                r_wait2 <= '0;
            else if (w_arb && r_wait2 != WAIT_SAT)
                r_wait2 <= r_wait2 + 1'b1;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_ram_addr = r_ram_addr;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_video_slot_arbiter.sv
// Directed bench for video_slot_arbiter: bus phases last 3 clks each, one slot per period.
module tb_video_slot_arbiter;
    import video_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    bus_cycle;
    logic [2:0]    req;
    logic [AW-1:0] addr0, addr1, addr2;
    logic          ram_read;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [2:0]    gnt;
    logic [2:0]    rd_valid;
    logic [DW-1:0] rd_data;

    int n_vec = 0;
    int n_bad = 0;

    video_slot_arbiter dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_bus_cycle (bus_cycle),
        .i_req       (req),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_addr2     (addr2),
        .o_ram_read  (ram_read),
        .o_ram_addr  (ram_addr),
        .i_ram_data  (ram_data),
        .o_gnt       (gnt),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        bit         skip;
        logic [2:0] gnt;
    } vec_t;

    vec_t tbl[$];

    localparam logic [AW-1:0] A0 = 23'h600000;
    localparam logic [AW-1:0] A1 = 23'h123456;
    localparam logic [AW-1:0] A2 = 23'h7ABCDE;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [2:0] g);
        case (g)
            3'b010:  return A1;
            3'b100:  return A2;
            default: return A0;
        endcase
    endfunction

    // Results of one bus period (t = 0..11; slot is t = 6..8, slot exit at t = 9).
    logic [2:0]    s_gnt, s_rdv, pr_gnt;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rdd;
    logic          pr_read;
    int            s_reads, s_pulses;

    task automatic run_period(input logic [2:0] req_v, input bit skip, input int drop_at,
                              input int rst_at, input logic [DW-1:0] data);
        int ph;
        s_reads  = 0;
        s_pulses = 0;
        s_gnt    = 'x;
        s_rdv    = 'x;
        pr_gnt   = 'x;
        pr_read  = 1'bx;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            #1;
            ph = t / 3;
            bus_cycle = (skip && ph == 2) ? 2'd3 : 2'(ph);
            if (t == 0) req = req_v;
            if (t == drop_at) req = 3'b000;
            reset = (t == rst_at);
            ram_data = data;
            @(negedge clk);
            if (ram_read) s_reads++;
            if (rd_valid != 3'b000) s_pulses++;
            if (t == 7) begin
                s_gnt  = gnt;
                s_addr = ram_addr;
            end
            if (t == 10) begin
                s_rdv = rd_valid;
                s_rdd = rd_data;
            end
            if (t == rst_at + 1) begin
                pr_gnt  = gnt;
                pr_read = ram_read;
            end
        end
    endtask

    logic [DW-1:0] data;

    initial begin
        reset     = 1'b1;
        bus_cycle = 2'd0;
        req       = 3'b000;
        addr0     = A0;
        addr1     = A1;
        addr2     = A2;
        ram_data  = '0;

        tbl.push_back('{3'b001, 1'b0, 3'b001});
        tbl.push_back('{3'b001, 1'b0, 3'b001});
        tbl.push_back('{3'b001, 1'b0, 3'b001});
        tbl.push_back('{3'b001, 1'b0, 3'b001});
        tbl.push_back('{3'b110, 1'b0, 3'b010});
        tbl.push_back('{3'b110, 1'b0, 3'b100});
        tbl.push_back('{3'b110, 1'b0, 3'b010});
        for (int i = 0; i < 4; i++) tbl.push_back('{3'b011, 1'b0, 3'b001});
        tbl.push_back('{3'b011, 1'b1, 3'b000});
        for (int i = 0; i < 4; i++) tbl.push_back('{3'b011, 1'b0, 3'b001});
        tbl.push_back('{3'b011, 1'b0, 3'b010});
        tbl.push_back('{3'b011, 1'b0, 3'b001});
        tbl.push_back('{3'b000, 1'b0, 3'b000});
        tbl.push_back('{3'b000, 1'b0, 3'b000});
        tbl.push_back('{3'b000, 1'b0, 3'b000});
        tbl.push_back('{3'b100, 1'b0, 3'b100});
        tbl.push_back('{3'b111, 1'b0, 3'b001});
        tbl.push_back('{3'b010, 1'b0, 3'b010});

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset ram_read", 64'(ram_read), 64'(0));
        chk("reset gnt", 64'(gnt), 64'(0));
        chk("reset rd_valid", 64'(rd_valid), 64'(0));
        chk("reset rd_data", rd_data, 64'(0));
        chk("reset ram_addr", 64'(ram_addr), 64'(0));

        foreach (tbl[i]) begin
            data = {32'hDA7A_0000 | 32'(i), 32'h5EED_1000 ^ 32'(i * 7)};
            run_period(tbl[i].req, tbl[i].skip, -1, -1, data);
            chk($sformatf("v%0d gnt", i), 64'(s_gnt), 64'(tbl[i].gnt));
            chk($sformatf("v%0d reads", i), 64'(s_reads), (tbl[i].gnt != 0) ? 64'(2) : 64'(0));
            chk($sformatf("v%0d rd_valid", i), 64'(s_rdv), 64'(tbl[i].gnt));
            chk($sformatf("v%0d pulses", i), 64'(s_pulses), (tbl[i].gnt != 0) ? 64'(1) : 64'(0));
            if (tbl[i].gnt != 0) begin
                chk($sformatf("v%0d ram_addr", i), 64'(s_addr), 64'(exp_addr(tbl[i].gnt)));
                chk($sformatf("v%0d rd_data", i), s_rdd, data);
            end
        end

        // Viking drops its request on the 2nd clk of its granted slot.
        data = 64'hFEED_FACE_0BAD_CAFE;
        run_period(3'b001, 1'b0, 7, -1, data);
        chk("drop gnt", 64'(s_gnt), 64'(3'b001));
        chk("drop reads", 64'(s_reads), 64'(2));
        chk("drop rd_valid", 64'(s_rdv), 64'(3'b001));
        chk("drop rd_data", s_rdd, data);

        // Reset on the 2nd clk of a granted slot (rr pointer currently at DMA).
        run_period(3'b001, 1'b0, -1, 7, 64'h1111_2222_3333_4444);
        chk("rst gnt before", 64'(s_gnt), 64'(3'b001));
        chk("rst ram_read after", 64'(pr_read), 64'(0));
        chk("rst gnt after", 64'(pr_gnt), 64'(0));
        chk("rst reads", 64'(s_reads), 64'(1));
        chk("rst pulses", 64'(s_pulses), 64'(0));
        data = 64'h0123_4567_89AB_CDEF;
        run_period(3'b110, 1'b0, -1, -1, data);
        chk("post-rst gnt", 64'(s_gnt), 64'(3'b010));
        chk("post-rst ram_addr", 64'(s_addr), 64'(A1));
        chk("post-rst rd_data", s_rdd, data);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
